// File: rtl/mov_pkg.sv
// Shared types and instruction-field layout for the MOV bus sequencer.
package mov_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MOV_OP = 4'b0001;
    localparam int         OP_W   = 4;

    // Instruction word is {opcode, dst, src} with src in the LSBs.
    localparam int SRC_LSB = 0;

    function automatic int dst_lsb(input int rw);
        return rw;
    endfunction

    function automatic int op_lsb(input int rw);
        return 2 * rw;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
    parameter int RW   = 2,
    parameter int NREG = 4
) (
    input  logic [RW-1:0]   sel,
    input  logic            en,
    output logic [NREG-1:0] dec
);

    // One output bit per register index, only the selected one when enabled.
    always_comb begin
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en && (int'(sel) == i)) dec[i] = 1'b1;
        end
    end

endmodule

// File: rtl/mov_bus_sequencer.sv
// Bus initiator: sequences one MOV at a time as source-drive, load, done.
module mov_bus_sequencer
    import mov_pkg::*;
#(
    parameter int         NREG   = 4,
    parameter int         RW     = 2,
    parameter int         DW     = 8,
    parameter int         SETTLE = 1,
    parameter logic [3:0] MOV_OP = mov_pkg::MOV_OP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4+2*RW-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DW-1:0]     bus,
    output logic [NREG-1:0]   oe,
    output logic [NREG-1:0]   ld,
    output logic              done,
    output logic              err,
    output logic [DW-1:0]     bus_q
);

    localparam int OP_LSB  = op_lsb(RW);
    localparam int DST_LSB = dst_lsb(RW);

    state_t          state_q, state_d;
    logic [RW-1:0]   src_q, src_d, dst_q, dst_d;
    logic            err_q, err_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREG-1:0] oe_nx, ld_nx;
    logic            illegal;

    wire [OP_W-1:0] op_i  = instr[OP_LSB +: OP_W];
    wire [RW-1:0]   dst_i = instr[DST_LSB +: RW];
    wire [RW-1:0]   src_i = instr[SRC_LSB +: RW];

    // Out-of-range indices only exist when NREG < 2**RW; treat them like a bad opcode.
    assign illegal = (op_i != MOV_OP) || (int'(src_i) >= NREG) || (int'(dst_i) >= NREG);

    // Next-state, field latching and settle countdown.
    // Only the illegal verdict of the opcode is kept; nothing else needs it.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    src_d = src_i;
                    dst_d = dst_i;
                    err_d = illegal;
                    if (illegal || (src_i == dst_i)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = 4'(SETTLE - 1);
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) state_d = LOAD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enables are decoded from the next state so the output flops are glitch-free.
    onehot_dec #(.RW(RW), .NREG(NREG)) u_oe_dec (
        .sel (src_d),
        .en  ((state_d == DRIVE) || (state_d == LOAD)),
        .dec (oe_nx)
    );

    onehot_dec #(.RW(RW), .NREG(NREG)) u_ld_dec (
        .sel (dst_d),
        .en  (state_d == LOAD),
        .dec (ld_nx)
    );

    // State, latched fields and registered Moore outputs; reset kills enables at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            oe          <= '0;
            ld          <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            oe          <= oe_nx;
            ld          <= ld_nx;
            done        <= (state_d == DONE);
            err         <= (state_d == DONE) && err_d;
            instr_ready <= (state_d == IDLE);
        end
    end

    // Debug capture of the bus on the same edge the destination loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                bus_q <= '0;
        else if (state_q == LOAD)  bus_q <= bus;
    end

    a_oe_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(oe));
    a_ld_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ld));
    a_ld_has_oe: assert property (@(posedge clk) disable iff (!rst_n) (ld == '0) || (oe != '0));
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) (oe & ld) == '0);

endmodule

// File: doc/mov_bus_sequencer.md
Name: mov_bus_sequencer

Overview:
- Initiator side of the shared 8-bit register bus.
- Accepts one MOV instruction at a time and sequences the bus transfer between 4-bit register slices, which are paired to form 8-bit registers.
- Drives exactly one source output-enable and then one destination load-enable; the destination register captures the bus on the clock edge that ends the load phase.
- Samples the bus value for debug and reports completion or illegal-opcode status.

Parameters:
- NREG, 4, number of 8-bit bus registers; one-hot enable width; must be a power of 2, with 2..8 legal.
- RW, 2, register-select field width; equals log2(NREG).
- DW, 8, bus data width.
- SETTLE, 1, number of DRIVE cycles with only the source enabled before the load phase; legal range 1..15.
- MOV_OP, 4'b0001, opcode value for MOV.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  4+2*RW  instruction word: [4+2*RW-1 -: 4] opcode, then dst[RW], then src[RW] (LSBs).
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept.
- bus  in  DW  resolved shared bus value, sampled by the sequencer.
- oe  out  NREG  one-hot source output-enable (M&N of the register pair).
- ld  out  NREG  one-hot destination load-enable (G1&G2 of the register pair).
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on an illegal opcode.
- bus_q  out  DW  bus value captured at the end of LOAD.

Behaviour:
- All outputs are registered, Moore-style from the state register.
- Reset, asynchronous:
  - state=IDLE, oe=0, ld=0, done=0, err=0, bus_q=0, settle counter=0, instr_ready=1.
  - Asserting reset mid-operation drops oe/ld immediately, with no clock needed.
  - A reset during LOAD leaves the destination register not loaded.
- States: IDLE, DRIVE, LOAD, DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid at the clock edge, latch src, dst and opcode.
  - Opcode != MOV_OP -> DONE with err flag set.
  - src == dst -> DONE, err=0; the bus is never driven.
  - Otherwise -> DRIVE, settle counter=SETTLE-1.
- DRIVE:
  - oe[src]=1, ld=0, instr_ready=0.
  - Counter decrements each cycle; when counter==0, go to LOAD.
- LOAD (exactly 1 cycle):
  - oe[src]=1, ld[dst]=1.
  - The edge leaving LOAD loads the destination register and captures bus_q<=bus.
  - Next state DONE.
- DONE (exactly 1 cycle):
  - done=1; err=1 only on an illegal opcode.
  - oe=0, ld=0, instr_ready=0; next state IDLE.
- Latency for a legal MOV:
  - Accepted at edge T0; oe rises after T0.
  - ld is high during cycle T0+SETTLE+1.
  - done is high during cycle T0+SETTLE+2.
  - Back-to-back acceptance is possible at edge T0+SETTLE+3.
- NOP / illegal opcode latency: done is high in the cycle after acceptance.
- Invariants (checked by assertions):
  - $onehot0(oe) and $onehot0(ld) at all times.
  - ld is never asserted without oe being asserted.
  - oe and ld never select the same index.
  - oe is high for SETTLE+1 consecutive cycles per MOV.
- instr_valid while instr_ready=0 is ignored; no instruction is queued.
- instr changes while busy have no effect; fields are latched at accept.
- A dst/src index >= NREG is impossible when NREG=2^RW; otherwise the instruction is treated as illegal (err).
- bus_q holds its value until the next LOAD.

Decomposition:
- Package mov_pkg:
  - state enum (IDLE, DRIVE, LOAD, DONE).
  - MOV_OP constant.
  - opcode/dst/src field offset constants.
- One sub-module, onehot_dec (RW -> NREG one-hot with enable), instantiated twice: once for oe from src, once for ld from dst.
- The sequencer FSM and settle counter live in mov_bus_sequencer.

Test Plan:
- Reset then idle, NREG=4, SETTLE=1 -> oe=0000, ld=0000, instr_ready=1, bus_q=0x00. Assert rst_n=0 mid-DRIVE -> oe=0000 before the next clk edge.
- MOV dst=2, src=1 (instr=8'b0001_10_01), bus model drives 0xA5 when oe[1] -> oe=0010 for 2 cycles, ld=0100 in the second of them, bus_q=0xA5, done pulse 3 cycles after accept, err=0.
- SETTLE=3, MOV dst=0, src=3 with bus=0x3C -> oe=1000 for 4 cycles, ld=0001 only in the last of them, done in cycle T0+5, bus_q=0x3C.
- MOV dst=1, src=1 (instr=8'b0001_01_01) -> oe and ld stay 0000 throughout, done=1 and err=0 in the next cycle, bus_q unchanged.
- Illegal opcode 4'b0110 -> done=1 and err=1 in the same single cycle, no oe/ld activity; the next legal MOV completes normally.
- Back-to-back: hold instr_valid=1 with two MOVs -> second accepted exactly at T0+SETTLE+3. An instr change during DRIVE does not alter oe. One-hot assertions never fire over 1000 random instructions.
